reg_load_arbiter: RTL and testbench
===================================

# reg_load_arbiter

Round-robin arbiter sharing the load ports of the 8-bit datapath registers between several requesters (control FSM, debug port, I/O unit). Each cycle it grants at most one requester. It registers that requester's data and target select, then drives exactly one register `load` pulse with the data on the next cycle. It sits between the requesters and the bank of load-enabled registers, which have no reset of their own and load `data` whenever `load` is high at a clock edge.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `NUM_REGS`, default 2: number of target registers, range 1..8.
- `DATA_W`, default 8: data width.
- `SEL_W`, derived: `max(1, clog2(NUM_REGS))`.
- `clk_i`  in  1: clock, rising edge.
- `rst_ni`  in  1: asynchronous active-low reset.
- `req_i`  in  NUM_REQ: request per requester, level, held until granted.
- `sel_i`  in  NUM_REQ*SEL_W: target register index per requester; requester k uses slice [k*SEL_W +: SEL_W].
- `data_i`  in  NUM_REQ*DATA_W: write data per requester; requester k uses slice [k*DATA_W +: DATA_W].
- `stall_i`  in  1: blocks new grants while high.
- `gnt_o`  out  NUM_REQ: one-hot grant, combinational, same cycle as acceptance.
- `load_o`  out  NUM_REGS: one-hot register load enables, registered.
- `data_o`  out  DATA_W: data to all register inputs, registered.
- `err_o`  out  1: one-cycle pulse for a granted request whose `sel` ≥ NUM_REGS, registered.

## Operation
- Priority pointer `ptr` (clog2(NUM_REQ) bits):
  - Search order is `ptr`, `ptr+1`, … `NUM_REQ-1`, `0`, … `ptr-1`, modulo NUM_REQ.
  - The first requester k with `req_i[k]=1` wins.
- Grant condition: `stall_i=0` and `|req_i`.
  - Set `gnt_o[k]=1`; all other bits are 0.
  - When the condition is false, `gnt_o=0`.
- At the clock edge of a grant:
  - `ptr <= (k+1) mod NUM_REQ`.
  - `data_o <= data_i` slice k.
  - If `sel` slice k < NUM_REGS, `load_o <= onehot(sel)`; otherwise `load_o <= 0` and `err_o <= 1`.
- Cycle with no grant: `load_o <= 0` and `err_o <= 0`. `data_o` holds its value and is don't-care to consumers.
- Handshake: a transfer occurs on any edge where `req_i[k] & gnt_o[k]`.
  - The requester may drop `req_i` or present a new transfer on the next cycle.
  - Back-to-back transfers from the same requester are allowed. Round-robin prevents them when others are waiting.
- Fairness: a continuously held request is granted within NUM_REQ non-stalled cycles.
- `stall_i` does not affect an already registered `load_o` pulse; that pulse still completes.
- Combinational paths: `req_i` and `stall_i` to `gnt_o` only. No combinational path from any input to `load_o`, `data_o` or `err_o`.

## Timing
- Reset (async assert, sync-safe release) values:
  - `ptr=0`, `load_o=0`, `data_o=0`, `err_o=0`.
  - `gnt_o` follows inputs; `ptr=0` means requester 0 has top priority.
- Reset mid-operation: a pending `load_o` pulse is cleared immediately. The target register does not load.
- Latency: grant in cycle N → `load_o`/`data_o` valid in cycle N+1 → target register output updated after the edge ending cycle N+1, i.e. visible in cycle N+2.
- Throughput: one load per cycle.
- Wrap-around: a grant to requester NUM_REQ-1 sets `ptr=0`.
- Simultaneous requests: only one grant per cycle; the losers keep requesting.
- A requester that changes `sel_i`/`data_i` while requesting but not granted: values at the grant edge are used.

## Test plan
- Reset:
  - Stimulus: assert `rst_ni=0` mid-cycle with a `load_o` pulse pending.
  - Required: `load_o`, `data_o` and `err_o` go to 0 immediately, without waiting for a clock edge. After release, `req_i=4'b1111` grants requester 0 first.
- Single transfer:
  - Stimulus: requester 2 with `sel=1`, `data=8'hA5` for one cycle.
  - Required: `gnt_o=4'b0100` in cycle N. `load_o=2'b10` and `data_o=8'hA5` in N+1 only. Register 1 reads `A5` in N+2.
- Round-robin:
  - Stimulus: `req_i=4'b1111` held for 6 cycles, with data = 10 + requester index.
  - Required: grant order 0,1,2,3,0,1. `data_o` sequence `0A,0B,0C,0D,0A,0B`, each one cycle after its grant.
- Stall:
  - Stimulus: `req_i=4'b0011`, `stall_i=1` for 3 cycles, then low.
  - Required: `gnt_o=0` and `load_o=0` during the stall. Grant goes to the requester at `ptr` on the first unstalled cycle.
- Invalid select:
  - Stimulus: `NUM_REGS=2` built with `SEL_W=2`, requester 1 with `sel=3`.
  - Required: the request is granted, `load_o=0`, and `err_o=1` for exactly one cycle. `ptr` advances to 2.
- Fairness:
  - Stimulus: requester 0 requests continuously while requester 3 raises a request.
  - Required: requester 3 is granted within 4 cycles. Requester 0 is never granted twice in a row while requester 3 waits.

Source files
------------

// File: rtl/reg_load_arbiter.sv
// Purpose: round-robin arbiter that shares the load ports of a register bank among requesters.
// Latency: grant is combinational in cycle N; load_o/data_o/err_o are registered and valid in cycle N+1.
// Backpressure: stall_i blocks new grants; a load pulse that is already registered still completes.
module reg_load_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 2,
  parameter int DATA_W   = 8,
  parameter int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*SEL_W-1:0]  sel_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  input  logic                      stall_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REGS-1:0]       load_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      err_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Requester that currently holds top priority.
  logic [PTR_W-1:0]    ptr_q;

  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic [SEL_W-1:0]    gnt_sel;
  logic [DATA_W-1:0]   gnt_dat;
  logic                sel_ok;
  logic [NUM_REGS-1:0] sel_onehot;

  // Search from ptr upward with wrap; the first active request wins unless stalled.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_vld && !stall_i && req_i[cand[PTR_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
    if (gnt_vld) gnt_o[gnt_idx] = 1'b1;
  end

  // Pick the winner's select and data, and decode the select into a load enable.
  always_comb begin
    gnt_sel    = sel_i[int'(gnt_idx)*SEL_W +: SEL_W];
    gnt_dat    = data_i[int'(gnt_idx)*DATA_W +: DATA_W];
    sel_ok     = (int'(gnt_sel) < NUM_REGS);
    sel_onehot = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sel_onehot[r] = (int'(gnt_sel) == r);
    end
  end

  // Register the granted transfer; out-of-range selects raise err_o instead of a load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      load_o <= '0;
      data_o <= '0;
      err_o  <= 1'b0;
    end else begin
      load_o <= '0;
      err_o  <= 1'b0;
      if (gnt_vld) begin
        ptr_q  <= (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        data_o <= gnt_dat;
        if (sel_ok) load_o <= sel_onehot;
        else        err_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: four requesters, two 8-bit target registers, 2-bit selects.
// Vectors drive at the falling edge; gnt_o is sampled mid-cycle, registered outputs 1ns after the rising edge.
// Expected registered outputs travel through a queue from the driving cycle to the cycle they appear.
module tb_reg_load_arbiter;

  localparam logic [31:0] D = 32'h0D0C0B0A;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  req_i = '0;
  logic [7:0]  sel_i = '0;
  logic [31:0] data_i = '0;
  logic        stall_i = 1'b0;
  logic [3:0]  gnt_o;
  logic [1:0]  load_o;
  logic [7:0]  data_o;
  logic        err_o;

  logic [7:0]  regs [2];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  req;
    logic        stall;
    logic [7:0]  sel;
    logic [31:0] dat;
    logic [3:0]  gnt;
    logic [1:0]  load;
    logic [7:0]  dout;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [1:0] load;
    logic [7:0] dout;
    logic       err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[16];

  reg_load_arbiter #(.NUM_REQ(4), .NUM_REGS(2), .DATA_W(8), .SEL_W(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .sel_i(sel_i),
    .data_i(data_i), .stall_i(stall_i), .gnt_o(gnt_o), .load_o(load_o),
    .data_o(data_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Load-enabled target registers with no reset, as in the real bank.
  always @(posedge clk_i) begin
    for (int r = 0; r < 2; r++) if (load_o[r]) regs[r] <= data_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check the grant, then check the registered result.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    @(negedge clk_i);
    req_i = v.req; stall_i = v.stall; sel_i = v.sel; data_i = v.dat;
    #1;
    chk({name, " gnt"}, {28'd0, gnt_o}, {28'd0, v.gnt});
    sb.push_back('{load: v.load, dout: v.dout, err: v.err});
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      chk({name, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, " load"}, {30'd0, load_o}, {30'd0, e.load});
      chk({name, " err"},  {31'd0, err_o},  {31'd0, e.err});
      chk({name, " data"}, {24'd0, data_o}, {24'd0, e.dout});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // Round-robin over four requesters with data 0A..0D
    tbl[0]  = '{4'b1111, 1'b0, 8'h00, D, 4'b0001, 2'b01, 8'h0A, 1'b0};
    tbl[1]  = '{4'b1111, 1'b0, 8'h00, D, 4'b0010, 2'b01, 8'h0B, 1'b0};
    tbl[2]  = '{4'b1111, 1'b0, 8'h00, D, 4'b0100, 2'b01, 8'h0C, 1'b0};
    tbl[3]  = '{4'b1111, 1'b0, 8'h00, D, 4'b1000, 2'b01, 8'h0D, 1'b0};
    tbl[4]  = '{4'b1111, 1'b0, 8'h00, D, 4'b0001, 2'b01, 8'h0A, 1'b0};
    tbl[5]  = '{4'b1111, 1'b0, 8'h00, D, 4'b0010, 2'b01, 8'h0B, 1'b0};
    // Move ptr to 0, then stall three cycles with requesters 0 and 1 waiting
    tbl[6]  = '{4'b1000, 1'b0, 8'h00, D, 4'b1000, 2'b01, 8'h0D, 1'b0};
    tbl[7]  = '{4'b0011, 1'b1, 8'h00, D, 4'b0000, 2'b00, 8'h0D, 1'b0};
    tbl[8]  = '{4'b0011, 1'b1, 8'h00, D, 4'b0000, 2'b00, 8'h0D, 1'b0};
    tbl[9]  = '{4'b0011, 1'b1, 8'h00, D, 4'b0000, 2'b00, 8'h0D, 1'b0};
    tbl[10] = '{4'b0011, 1'b0, 8'h00, D, 4'b0001, 2'b01, 8'h0A, 1'b0};
    // Requester 1 selects register 3, which does not exist
    tbl[11] = '{4'b0010, 1'b0, 8'h0C, D, 4'b0010, 2'b00, 8'h0B, 1'b1};
    tbl[12] = '{4'b0000, 1'b0, 8'h00, D, 4'b0000, 2'b00, 8'h0B, 1'b0};
    // ptr now 2; requester 3 targets register 1, then wrap to requester 0
    tbl[13] = '{4'b1111, 1'b0, 8'h00, D, 4'b0100, 2'b01, 8'h0C, 1'b0};
    tbl[14] = '{4'b1111, 1'b0, 8'h40, D, 4'b1000, 2'b10, 8'h0D, 1'b0};
    tbl[15] = '{4'b1111, 1'b0, 8'h00, D, 4'b0001, 2'b01, 8'h0A, 1'b0};

    #1;
    chk("reset load", {30'd0, load_o}, 32'd0);
    chk("reset data", {24'd0, data_o}, 32'd0);
    chk("reset err",  {31'd0, err_o},  32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Single transfer: requester 2 writes A5 to register 1 (ptr is 1)
    apply('{4'b0100, 1'b0, 8'h10, 32'h0DA50B0A, 4'b0100, 2'b10, 8'hA5, 1'b0}, "single");
    apply('{4'b0000, 1'b0, 8'h00, D, 4'b0000, 2'b00, 8'hA5, 1'b0}, "single idle");
    chk("single reg1", {24'd0, regs[1]}, 32'h0000_00A5);

    // Fairness: requester 0 keeps asking, requester 3 joins and must win next (ptr is 3)
    apply('{4'b0001, 1'b0, 8'h00, D, 4'b0001, 2'b01, 8'h0A, 1'b0}, "fair0");
    apply('{4'b1001, 1'b0, 8'h00, D, 4'b1000, 2'b01, 8'h0D, 1'b0}, "fair1");
    apply('{4'b0001, 1'b0, 8'h00, D, 4'b0001, 2'b01, 8'h0A, 1'b0}, "fair2");

    // Reset while a load pulse to register 1 is pending (ptr is 1)
    @(negedge clk_i);
    req_i = 4'b0100; sel_i = 8'h10; data_i = 32'h0D5A0B0A; stall_i = 1'b0;
    #1;
    chk("mid gnt", {28'd0, gnt_o}, 32'h4);
    @(posedge clk_i);
    #1;
    chk("mid load before", {30'd0, load_o}, 32'h2);
    chk("mid data before", {24'd0, data_o}, 32'h5A);
    req_i = 4'b0000;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid load cleared", {30'd0, load_o}, 32'd0);
    chk("mid data cleared", {24'd0, data_o}, 32'd0);
    chk("mid err cleared",  {31'd0, err_o},  32'd0);
    @(posedge clk_i);
    #1;
    chk("mid reg1 kept", {24'd0, regs[1]}, 32'h0000_00A5);
    @(negedge clk_i);
    rst_ni = 1'b1;
    apply('{4'b1111, 1'b0, 8'h00, D, 4'b0001, 2'b01, 8'h0A, 1'b0}, "post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
